// File: rtl/npc_ifu.sv
// Decoupled instruction fetch unit: one outstanding bus request, QDEPTH-entry {pc, inst} queue.
// Optional IFU_LINE_REUSE_EN keeps the upper word of a 64-bit response as a spare instruction.
module npc_ifu #(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned BUS_W    = 64,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [BUS_W-1:0] mem_resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  inst_pc,
    output logic             busy
);

    localparam int unsigned     PW        = $clog2(QDEPTH);
    localparam logic [PW:0]     Depth     = (PW+1)'(QDEPTH);
    localparam logic [XLEN-1:0] RstPc     = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] AlignMask = ~XLEN'(BUS_W / 8 - 1);

    typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [PW-1:0]   head_q, tail_q;
    logic [PW:0]     count_q;
    logic [31:0]     q_inst [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];

    logic        not_full;
    logic        resp_take;
    logic        spare_push;
    logic        push;
    logic        pop;
    logic [63:0] resp_ext;
    logic [31:0] resp_word;
    logic [31:0] push_inst;

    assign not_full  = count_q < Depth;
    // A response arriving with a redirect belongs to the old stream.
    assign resp_take = (state_q == StWait) && mem_resp_valid && !redirect_valid;
    assign resp_ext  = 64'(mem_resp_data);

    always_comb begin
        resp_word = resp_ext[31:0];
        if (BUS_W == 64 && fpc_q[2]) begin
            resp_word = resp_ext[63:32];
        end
    end

`ifdef IFU_LINE_REUSE_EN
    localparam bit Reuse = (BUS_W == 64);

    logic        spare_valid_q;
    logic [31:0] spare_q;

    assign spare_push = Reuse && spare_valid_q && (state_q == StReq) && not_full &&
                        !redirect_valid;
    assign push_inst  = spare_push ? spare_q : resp_word;

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            spare_valid_q <= 1'b0;
        end else if (resp_take && Reuse && !fpc_q[2]) begin
            spare_valid_q <= 1'b1;
            spare_q       <= resp_ext[63:32];
        end else if (spare_push) begin
            spare_valid_q <= 1'b0;
        end
    end
`else
    assign spare_push = 1'b0;
    assign push_inst  = resp_word;
`endif

    assign push = resp_take || spare_push;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (mem_req_valid && mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    state_d = StReq;
                end else if (redirect_valid) begin
                    state_d = StDrop;
                end
            end
            // A redirect here leaves the single stale response still to be swallowed.
            StDrop: begin
                if (mem_resp_valid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_req_valid = (state_q == StReq) && not_full && !redirect_valid && !spare_push;
        busy          = (state_q != StReq);
    end

    always_comb begin
        fpc_d = fpc_q;
        if (redirect_valid) begin
            fpc_d = redirect_pc & ~XLEN'(3);
        end else if (push) begin
            fpc_d = fpc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q <= RstPc;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    assign mem_req_addr = fpc_q & AlignMask;

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail_q] <= push_inst;
            q_pc[tail_q]   <= fpc_q;
        end
    end

    assign inst_valid = (count_q != '0);
    assign inst       = inst_valid ? q_inst[head_q] : '0;
    assign inst_pc    = inst_valid ? q_pc[head_q] : '0;

endmodule

// File: tb/tb_npc_ifu.sv
// Randomised self-checking bench for npc_ifu with a latency-randomised memory model.
// The consumed instruction stream is checked against a sequential-PC reference model.
module tb_npc_ifu;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned BUS_W  = 64;
    localparam int unsigned QDEPTH = 4;
    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic             clk;
    logic             rst;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [XLEN-1:0]  mem_req_addr;
    logic             mem_resp_valid;
    logic [BUS_W-1:0] mem_resp_data;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int lat_min = 0;
    int lat_max = 0;
    int ready_pct = 100;
    logic [63:0] req_log [$];

    npc_ifu #(
        .XLEN    (XLEN),
        .RESET_PC(RST_PC),
        .BUS_W   (BUS_W),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        if (a == 64'h8000_0000) return 64'h0010_0073_0000_0013;
        lo = (a[31:0] * 32'h9e37_79b1) ^ 32'h0000_0013;
        return {lo ^ 32'h5a5a_0000 ^ a[31:0], lo};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] w;
        w = mem_word(pc & ~64'h7);
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    // Memory: one outstanding request, response after 1+lat cycles, cleared by reset.
    initial begin : memory
        logic        s_rst;
        logic        s_hs;
        logic [63:0] s_addr;
        logic [63:0] p_addr;
        bit          pending;
        int          lat;
        pending = 0;
        lat = 0;
        p_addr = '0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(negedge clk);
            s_rst  = rst;
            s_hs   = mem_req_valid && mem_req_ready;
            s_addr = mem_req_addr;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (s_rst) begin
                pending = 0;
            end else begin
                if (s_hs) begin
                    req_log.push_back(s_addr);
                    pending = 1;
                    p_addr = s_addr;
                    lat = int'($urandom_range(lat_max, lat_min));
                end
                if (pending) begin
                    if (lat == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data = mem_word(p_addr);
                        pending = 0;
                    end else begin
                        lat--;
                    end
                end
            end
            mem_req_ready = ($urandom_range(99) < ready_pct);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        req_log.delete();
    endtask

    task automatic test_reset();
        ready_pct = 0;
        do_reset();
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1) begin errors++;
            $display("FAIL reset_req_valid got %0b want 1", mem_req_valid); end
        checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++;
            $display("FAIL reset_req_addr got %h want 80000000", mem_req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++;
            $display("FAIL reset_inst_valid got %0b want 0", inst_valid); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (inst !== 32'h0 || inst_pc !== 64'h0) begin errors++;
            $display("FAIL reset_head got %h/%h want 0/0", inst_pc, inst); end
    endtask

    task automatic test_stream();
        logic [63:0] pcs [2];
        logic [31:0] ins [2];
        int n;
        n = 0;
        ready_pct = 100;
        lat_min = 0;
        lat_max = 2;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 60 && n < 2; c++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                pcs[n] = inst_pc;
                ins[n] = inst;
                n++;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (n != 2) begin errors++;
            $display("FAIL stream_count got %0d want 2", n);
        end else begin
            if (pcs[0] !== 64'h8000_0000 || ins[0] !== 32'h0000_0013) begin errors++;
                $display("FAIL stream_head0 got %h/%h want 80000000/00000013", pcs[0], ins[0]); end
            checks++;
            if (pcs[1] !== 64'h8000_0004 || ins[1] !== 32'h0010_0073) begin errors++;
                $display("FAIL stream_head1 got %h/%h want 80000004/00100073", pcs[1], ins[1]); end
        end
        checks++;
        if (req_log.size() < 2) begin errors++;
            $display("FAIL stream_reqs got %0d requests want >=2", req_log.size());
        end else begin
`ifdef IFU_LINE_REUSE_EN
            if (req_log[0] !== 64'h8000_0000 || req_log[1] !== 64'h8000_0008) begin errors++;
                $display("FAIL stream_req_addr got %h,%h want 80000000,80000008",
                         req_log[0], req_log[1]); end
`else
            if (req_log[0] !== 64'h8000_0000 || req_log[1] !== 64'h8000_0000) begin errors++;
                $display("FAIL stream_req_addr got %h,%h want 80000000,80000000",
                         req_log[0], req_log[1]); end
`endif
        end
    endtask

    task automatic test_backpressure();
`ifdef IFU_LINE_REUSE_EN
        int exp_reqs = 2;
`else
        int exp_reqs = 4;
`endif
        ready_pct = 100;
        lat_min = 0;
        lat_max = 2;
        do_reset();
        repeat (60) @(negedge clk);
        checks++; if (req_log.size() != exp_reqs) begin errors++;
            $display("FAIL bp_fill_reqs got %0d want %0d", req_log.size(), exp_reqs); end
        checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b1) begin errors++;
            $display("FAIL bp_full got req_valid=%0b inst_valid=%0b want 0/1",
                     mem_req_valid, inst_valid); end
        checks++; if (inst_pc !== 64'h8000_0000) begin errors++;
            $display("FAIL bp_head got %h want 80000000", inst_pc); end
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (req_log.size() != exp_reqs + 1) begin errors++;
            $display("FAIL bp_refill_reqs got %0d want %0d", req_log.size(), exp_reqs + 1);
        end else if (req_log[exp_reqs] !== 64'h8000_0010) begin errors++;
            $display("FAIL bp_refill_addr got %h want 80000010", req_log[exp_reqs]);
        end
        checks++; if (mem_req_valid !== 1'b0 || inst_pc !== 64'h8000_0004) begin errors++;
            $display("FAIL bp_after_pop got req_valid=%0b head=%h want 0/80000004",
                     mem_req_valid, inst_pc); end
    endtask

    task automatic test_redirect_wait();
        int n;
        int base;
        ready_pct = 100;
        lat_min = 3;
        lat_max = 3;
        do_reset();
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0104;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        base = req_log.size();
        checks++; if (busy !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_drop got busy=%0b req=%0b iv=%0b want 1/0/0",
                     busy, mem_req_valid, inst_valid); end
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (busy !== 1'b0 || inst_valid !== 1'b0 || mem_req_valid !== 1'b1 ||
                      mem_req_addr !== 64'h8000_0100) begin errors++;
            $display("FAIL rw_after_drop got busy=%0b iv=%0b req=%0b addr=%h want 0/0/1/80000100",
                     busy, inst_valid, mem_req_valid, mem_req_addr); end
        n = 0;
        while (!inst_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (inst_pc !== 64'h8000_0104 || inst !== exp_inst(64'h8000_0104)) begin
            errors++;
            $display("FAIL rw_first_head got %h/%h want 80000104/%h", inst_pc, inst,
                     exp_inst(64'h8000_0104)); end
        checks++;
        if (req_log.size() <= base || req_log[base] !== 64'h8000_0100) begin errors++;
            $display("FAIL rw_req_addr got %0d entries want entry %0d = 80000100",
                     req_log.size(), base); end
    endtask

    task automatic test_redirect_resp();
        int n;
        ready_pct = 100;
        lat_min = 1;
        lat_max = 1;
        do_reset();
        inst_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0208;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL rr_in_wait got busy=%0b want 1", busy); end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || inst_valid !== 1'b0 || mem_req_valid !== 1'b1 ||
                      mem_req_addr !== 64'h8000_0208) begin errors++;
            $display("FAIL rr_after got busy=%0b iv=%0b req=%0b addr=%h want 0/0/1/80000208",
                     busy, inst_valid, mem_req_valid, mem_req_addr); end
        n = 0;
        while (!inst_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++; if (inst_pc !== 64'h8000_0208 || inst !== exp_inst(64'h8000_0208)) begin
            errors++;
            $display("FAIL rr_first_head got %h/%h want 80000208/%h", inst_pc, inst,
                     exp_inst(64'h8000_0208)); end
    endtask

    // Reference: decode must see consecutive PCs from the last reset/redirect target.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] prev_addr;
        logic        prev_stall;
        int          pops;
        exp_pc = RST_PC;
        prev_stall = 1'b0;
        prev_addr = '0;
        pops = 0;
        ready_pct = 70;
        lat_min = 0;
        lat_max = 3;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(999) < 3);
            redirect_valid = !rst && ($urandom_range(99) < 4);
            redirect_pc = {32'h0, 32'h8000_0000 + 32'($urandom_range(4095))};
            inst_ready = ($urandom_range(99) < 60);
            @(negedge clk);
            if (prev_stall && !redirect_valid) begin
                checks++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr) begin errors++;
                    $display("FAIL rnd_req_hold got %0b/%h want 1/%h", mem_req_valid,
                             mem_req_addr, prev_addr); end
            end
            if (mem_req_valid) begin
                checks++;
                if (mem_req_addr[2:0] !== 3'b000) begin errors++;
                    $display("FAIL rnd_req_align got %h want 8-byte aligned", mem_req_addr); end
            end
            prev_stall = mem_req_valid && !mem_req_ready && !rst;
            prev_addr = mem_req_addr;
            if (rst) begin
                exp_pc = RST_PC;
            end else if (redirect_valid) begin
                exp_pc = redirect_pc & ~64'h3;
            end else if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== exp_inst(exp_pc)) begin errors++;
                    $display("FAIL rnd_head got %h/%h want %h/%h", inst_pc, inst, exp_pc,
                             exp_inst(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        checks++; if (pops < 100) begin errors++;
            $display("FAIL rnd_progress got %0d pops want >=100", pops); end
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        tick();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_ifu.md
Name: npc_ifu

Overview:
Parametrised instruction fetch unit for the npc core. It replaces the single-cycle PC register and direct instruction read with a decoupled front end. It owns the fetch PC and issues aligned requests on a valid/ready memory port, one request outstanding at a time. It selects the 32-bit instruction from the bus word and buffers {pc, inst} pairs in a QDEPTH-entry queue. Decode consumes the queue through a valid/ready port, and execute can flush and redirect it.

Parameters:
XLEN, 64, address/PC width.
RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded by reset (truncated to XLEN).
BUS_W, 64, memory data width; legal values 32 or 64.
QDEPTH, 4, fetch-queue entries; power of 2, >= 2.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset, synchronous, active-high.
redirect_valid  in  1  execute requests flush and new fetch PC.
redirect_pc  in  XLEN  new fetch PC; bits[1:0] ignored (treated as 0).
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts request.
mem_req_addr  out  XLEN  fetch PC aligned down to BUS_W/8 bytes.
mem_resp_valid  in  1  response data valid (single cycle, in order).
mem_resp_data  in  BUS_W  response word.
inst_valid  out  1  queue head valid.
inst_ready  in  1  decode consumes head.
inst  out  32  head instruction.
inst_pc  out  XLEN  head PC.
busy  out  1  request outstanding (state WAIT or DROP).

Behaviour:
- Reset, while rst=1 at the clock edge:
  - fpc <= RESET_PC; queue empty; state <= REQ; spare cleared.
  - Outputs in the first cycle after rst falls: inst_valid=0, busy=0, inst=0, inst_pc=0.
- States:
  - REQ: mem_req_valid = (count<QDEPTH) & !redirect_valid & !spare_push. On handshake, go to WAIT.
  - WAIT: await mem_resp_valid. On response, push {fpc, selected word}, fpc += 4, go to REQ.
  - DROP: discard the next mem_resp_valid, then go to REQ.
- The first request is asserted in the first cycle after reset releases, with mem_req_addr=RESET_PC.
- Word select:
  - BUS_W=64: inst = fpc[2] ? data[63:32] : data[31:0].
  - BUS_W=32: inst = data.
- Latency: the response is pushed on its clock edge; inst_valid rises the following cycle if the queue was empty.
- Queue:
  - Circular buffer with a count register; the head is read combinationally.
  - Push and pop in the same cycle leave count unchanged, and this is legal when full.
  - Pointers wrap modulo QDEPTH.
  - A request is issued only when count<QDEPTH, so a push never overflows.
- Redirect (redirect_valid=1 at an edge):
  - Queue cleared: any pop that cycle is discarded, count=0.
  - fpc <= {redirect_pc[XLEN-1:2], 2'b00}; spare cleared.
  - From WAIT with no response that cycle, go to DROP.
  - From WAIT with a response that same cycle, the response is discarded and state goes to REQ.
  - From DROP, stay in DROP.
  - From REQ, stay in REQ (no handshake is possible that cycle).
- Consecutive redirects: the last one wins; at most one stale response is ever outstanding.
- rst asserted mid-transaction: state returns to REQ. The memory must also be reset; no stale-response tracking across reset.
- mem_req_addr and mem_req_valid are held stable until handshake, except when withdrawn by a redirect.

Optional Feature:
IFU_LINE_REUSE_EN:
- When defined and BUS_W=64, a response with fpc[2]=0 pushes the low word and latches data[63:32] as the spare.
- Next cycle in REQ with spare valid and count<QDEPTH: spare_push pushes {fpc, spare}, fpc += 4, and the spare is cleared. No memory request is made that cycle.
- Redirect or reset clears the spare.
- Sequential fetch then costs one request per 8 bytes.
- When undefined, or when BUS_W=32: no spare register; every instruction costs one request.

Test Plan:
- Reset sequence: rst high 2 cycles → first cycle after release shows mem_req_valid=1, mem_req_addr=0x80000000, inst_valid=0, busy=0.
- Stream, inst_ready=1: memory returns 0x0010007300000013 for 0x80000000 → heads (0x80000000, 0x00000013) then (0x80000004, 0x00100073). Without the feature, requests go to 0x80000000 twice.
- Backpressure, QDEPTH=4, inst_ready=0 → exactly 4 pushes, then mem_req_valid stays 0. Pulsing inst_ready for 1 cycle → one pop, then exactly one new request at the next PC.
- Redirect to 0x80000104 while in WAIT → the stale response is dropped and the queue reads empty. The next request addr is 0x80000100, and the first head is (0x80000104, upper word).
- Redirect in the same cycle as mem_resp_valid → no push, state returns to REQ, and the next request targets redirect_pc.
- With IFU_LINE_REUSE_EN: sequential run from 0x80000000 for 4 instructions → requests only to 0x80000000 and 0x80000008. Heads appear at PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000C.
